// File: rtl/u111_bus_arbiter.sv
// U111 local-bus arbiter: hands the 68040 bus between the CPU (default owner)
// and one DMA master, with a dead-bus turnaround on every ownership change.
module u111_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_TENURE  = 64,
  parameter int CNT_W       = 8
) (
  input  logic       CLK40,
  input  logic       RESET,
  input  logic       DMA_REQn,
  input  logic       DMA_BBn,
  input  logic       CPU_BRn,
  input  logic       CPU_BBn,
  input  logic       LOCKn,
  input  logic       LBENn,
  input  logic       RnW,
  output logic       BGn,
  output logic       DMA_GNTn,
  output logic       DMAn,
  output logic       BUFENn,
  output logic       BUFDIR,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    CPU_OWN  = 3'd0,
    ARB      = 3'd1,
    TURN_IN  = 3'd2,
    DMA_OWN  = 3'd3,
    REL      = 3'd4,
    TURN_OUT = 3'd5
  } state_e;

  localparam logic [2:0]       TURN_LAST  = 3'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TENURE_MAX = CNT_W'(MAX_TENURE);

  state_e           state_q;
  logic [2:0]       turn_q;
  logic [CNT_W-1:0] tenure_q;
  logic             fair_q;
  logic             bgn_q;
  logic             dma_gntn_q;
  logic             dman_q;

  logic             turn_done;
  logic [CNT_W-1:0] tenure_inc;
  logic             forced_rel;

  // Request/grant protocol: a master requests with its REQ low and may drive
  // the bus only while its grant is low; it signals an unfinished cycle with BB low.
  assign turn_done  = (turn_q == TURN_LAST);
  assign tenure_inc = (&tenure_q) ? tenure_q : tenure_q + CNT_W'(1);
  // tenure_inc counts the DMA_OWN cycle now completing, so release lands after exactly MAX_TENURE cycles
  assign forced_rel = (MAX_TENURE != 0) && (tenure_inc >= TENURE_MAX) && !CPU_BRn;

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state_q    <= CPU_OWN;
      turn_q     <= 3'd0;
      tenure_q   <= '0;
      fair_q     <= 1'b0;
      bgn_q      <= 1'b0;
      dma_gntn_q <= 1'b1;
      dman_q     <= 1'b1;
    end else begin
      case (state_q)
        CPU_OWN: begin
          if (!CPU_BBn) fair_q <= 1'b0;
          if (!DMA_REQn && LOCKn && !fair_q) begin
            state_q <= ARB;
            bgn_q   <= 1'b1;
          end
        end
        ARB: begin
          if (LOCKn) begin
            if (DMA_REQn) begin
              state_q <= CPU_OWN;
              bgn_q   <= 1'b0;
            end else if (CPU_BBn) begin
              state_q <= TURN_IN;
              turn_q  <= 3'd0;
            end
          end
        end
        TURN_IN: begin
          if (turn_done) begin
            state_q    <= DMA_OWN;
            turn_q     <= 3'd0;
            tenure_q   <= '0;
            dma_gntn_q <= 1'b0;
            dman_q     <= 1'b0;
          end else begin
            turn_q <= turn_q + 3'd1;
          end
        end
        DMA_OWN: begin
          tenure_q <= tenure_inc;
          if (DMA_REQn || forced_rel) begin
            state_q    <= REL;
            tenure_q   <= '0;
            dma_gntn_q <= 1'b1;
            // Master was still requesting: make it wait for a CPU bus cycle before re-arbitrating
            fair_q     <= !DMA_REQn;
          end
        end
        REL: begin
          if (DMA_BBn) begin
            state_q <= TURN_OUT;
            turn_q  <= 3'd0;
            dman_q  <= 1'b1;
          end
        end
        TURN_OUT: begin
          if (turn_done) begin
            state_q <= CPU_OWN;
            turn_q  <= 3'd0;
            bgn_q   <= 1'b0;
          end else begin
            turn_q <= turn_q + 3'd1;
          end
        end
        default: begin
          state_q    <= CPU_OWN;
          turn_q     <= 3'd0;
          tenure_q   <= '0;
          bgn_q      <= 1'b0;
          dma_gntn_q <= 1'b1;
          dman_q     <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    BUFENn = 1'b1;
    BUFDIR = 1'b0;
    case (state_q)
      CPU_OWN, ARB: begin
        BUFENn = ~LBENn;
        BUFDIR = RnW;
      end
      DMA_OWN, REL: begin
        BUFENn = 1'b0;
        BUFDIR = ~RnW;
      end
      default: begin
        BUFENn = 1'b1;
        BUFDIR = 1'b0;
      end
    endcase
  end

  assign BGn         = bgn_q;
  assign DMA_GNTn    = dma_gntn_q;
  assign DMAn        = dman_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_u111_bus_arbiter.sv
// Bench for u111_bus_arbiter: directed handoff scenarios followed by random
// traffic, all checked against an ownership-level reference model.
module tb_u111_bus_arbiter;

  localparam int TURN = 1;
  localparam int MAXT = 4;
  localparam int CW   = 8;

  logic       CLK40 = 1'b0;
  logic       RESET = 1'b1;
  logic       DMA_REQn = 1'b1, DMA_BBn = 1'b1, CPU_BRn = 1'b1, CPU_BBn = 1'b1;
  logic       LOCKn = 1'b1, LBENn = 1'b1, RnW = 1'b1;
  logic       BGn, DMA_GNTn, DMAn, BUFENn, BUFDIR;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the bus, expressed as ownership phases
  bit m_cpu, m_arb, m_dma, m_drain, m_gap_in, m_fair;
  int m_gap, m_ten;

  // Turnaround monitor
  int   dead_run;
  bit   came_from_dma;
  logic prev_gnt, prev_bg;

  u111_bus_arbiter #(.TURN_CYCLES(TURN), .MAX_TENURE(MAXT), .CNT_W(CW)) dut (
    .CLK40(CLK40), .RESET(RESET), .DMA_REQn(DMA_REQn), .DMA_BBn(DMA_BBn),
    .CPU_BRn(CPU_BRn), .CPU_BBn(CPU_BBn), .LOCKn(LOCKn), .LBENn(LBENn), .RnW(RnW),
    .BGn(BGn), .DMA_GNTn(DMA_GNTn), .DMAn(DMAn), .BUFENn(BUFENn), .BUFDIR(BUFDIR),
    .dbg_state_o(dbg_state)
  );

  always #5 CLK40 = ~CLK40;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cpu = 1; m_arb = 0; m_dma = 0; m_drain = 0; m_gap_in = 0; m_fair = 0;
    m_gap = 0; m_ten = 0;
    dead_run = 0; came_from_dma = 0; prev_gnt = 1'b1; prev_bg = 1'b0;
  endtask

  task automatic model_step();
    bit go, forced;
    if (m_cpu) begin
      go = !DMA_REQn && LOCKn && !m_fair;
      if (!CPU_BBn) m_fair = 0;
      if (go) begin m_cpu = 0; m_arb = 1; end
    end else if (m_arb) begin
      if (LOCKn) begin
        if (DMA_REQn) begin m_arb = 0; m_cpu = 1; end
        else if (CPU_BBn) begin m_arb = 0; m_gap = TURN; m_gap_in = 1; end
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        if (m_gap_in) begin m_dma = 1; m_ten = 0; end
        else m_cpu = 1;
      end
    end else if (m_dma) begin
      if (m_ten < (2**CW) - 1) m_ten++;
      forced = (MAXT != 0) && (m_ten >= MAXT) && !CPU_BRn;
      if (!DMA_REQn == 0 || forced) begin
        m_dma = 0; m_drain = 1; m_fair = !DMA_REQn;
      end
    end else if (m_drain) begin
      if (DMA_BBn) begin m_drain = 0; m_gap = TURN; m_gap_in = 0; end
    end
  endtask

  task automatic check_all();
    logic ebuf, edir;
    if (m_cpu || m_arb) begin ebuf = ~LBENn; edir = RnW; end
    else if (m_dma || m_drain) begin ebuf = 1'b0; edir = ~RnW; end
    else begin ebuf = 1'b1; edir = 1'b0; end
    chk("bgn", BGn, !m_cpu);
    chk("dma_gntn", DMA_GNTn, !m_dma);
    chk("dman", DMAn, !(m_dma || m_drain));
    chk("bufenn", BUFENn, ebuf);
    chk("bufdir", BUFDIR, edir);
    chk("grant_excl", BGn | DMA_GNTn, 1'b1);
    if (prev_gnt && !DMA_GNTn) chk("turn_gap_in", dead_run >= TURN, 1'b1);
    if (prev_bg && !BGn && came_from_dma) chk("turn_gap_out", dead_run >= TURN, 1'b1);
    if (!BGn) came_from_dma = 0;
    if (!DMAn) came_from_dma = 1;
    dead_run = (BUFENn && BGn && DMA_GNTn && DMAn) ? dead_run + 1 : 0;
    prev_gnt = DMA_GNTn;
    prev_bg  = BGn;
  endtask

  task automatic tick();
    @(posedge CLK40);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive_random();
    DMA_REQn = ($urandom_range(0, 9) < 3);
    LOCKn    = ($urandom_range(0, 9) != 0);
    CPU_BBn  = $urandom_range(0, 1);
    DMA_BBn  = $urandom_range(0, 1);
    CPU_BRn  = $urandom_range(0, 1);
    LBENn    = $urandom_range(0, 1);
    RnW      = $urandom_range(0, 1);
  endtask

  initial begin
    // Power-on reset
    model_reset();
    repeat (2) @(posedge CLK40);
    #1;
    chk("rst_bgn", BGn, 1'b0);
    chk("rst_gnt", DMA_GNTn, 1'b1);
    chk("rst_dman", DMAn, 1'b1);
    @(negedge CLK40);
    RESET = 1'b0;

    // Basic handoff
    DMA_REQn = 1'b0; CPU_BBn = 1'b1; RnW = 1'b1; LBENn = 1'b1;
    tick(); chk("handoff_bg_off", BGn, 1'b1);
    tick(); chk("handoff_dead", BUFENn, 1'b1);
    tick(); chk("handoff_gnt", DMA_GNTn, 1'b0);
    chk("handoff_dman", DMAn, 1'b0);
    chk("handoff_dir", BUFDIR, ~RnW);
    repeat (2) tick();
    DMA_REQn = 1'b1; DMA_BBn = 1'b0;
    tick(); chk("rel_gnt", DMA_GNTn, 1'b1); chk("rel_dman", DMAn, 1'b0);
    tick();
    DMA_BBn = 1'b1;
    tick(); chk("turnout_dman", DMAn, 1'b1); chk("turnout_dead", BUFENn, 1'b1);
    tick(); chk("back_cpu", BGn, 1'b0);

    // Lock hold, then withdrawal from ARB
    LOCKn = 1'b0; DMA_REQn = 1'b0; CPU_BBn = 1'b0;
    repeat (10) begin tick(); chk("lock_hold", BGn, 1'b0); end
    LOCKn = 1'b1;
    tick(); chk("lock_release", BGn, 1'b1);
    DMA_REQn = 1'b1;
    tick(); chk("withdraw_bg", BGn, 1'b0);

    // Withdrawn request with the CPU bus busy
    LBENn = 1'b1; DMA_REQn = 1'b0; CPU_BBn = 1'b0;
    repeat (2) begin tick(); chk("withdraw_buf", BUFENn, 1'b0); end
    DMA_REQn = 1'b1;
    tick(); chk("withdraw_bg2", BGn, 1'b0); chk("withdraw_buf2", BUFENn, 1'b0);

    // Forced release after MAXT cycles with the CPU requesting
    CPU_BBn = 1'b1; DMA_REQn = 1'b0; CPU_BRn = 1'b1;
    repeat (2) tick();
    tick(); chk("forced_gnt_on", DMA_GNTn, 1'b0);
    CPU_BRn = 1'b0; DMA_BBn = 1'b0;
    repeat (MAXT - 1) begin tick(); chk("forced_tenure", DMA_GNTn, 1'b0); end
    tick(); chk("forced_gnt_off", DMA_GNTn, 1'b1); chk("forced_dman", DMAn, 1'b0);
    repeat (2) begin tick(); chk("forced_drain", DMAn, 1'b0); end
    DMA_BBn = 1'b1;
    tick(); chk("forced_turnout", DMAn, 1'b1);
    tick(); chk("forced_cpu", BGn, 1'b0);
    repeat (3) begin tick(); chk("fair_block", BGn, 1'b0); end
    CPU_BBn = 1'b0;
    tick(); chk("fair_clear", BGn, 1'b0);
    CPU_BBn = 1'b1;
    tick(); chk("fair_rearb", BGn, 1'b1);

    // Reset while the DMA master owns the bus
    CPU_BRn = 1'b1;
    repeat (2) tick();
    chk("middma_gnt", DMA_GNTn, 1'b0);
    #2;
    RESET = 1'b1; DMA_REQn = 1'b1;
    model_reset();
    #1;
    chk("middma_rst_bgn", BGn, 1'b0);
    chk("middma_rst_gnt", DMA_GNTn, 1'b1);
    chk("middma_rst_dman", DMAn, 1'b1);
    @(negedge CLK40);
    RESET = 1'b0;
    LBENn = 1'b0; RnW = 1'b0;
    #1; chk("cpu_buf_a", BUFENn, 1'b1); chk("cpu_dir_a", BUFDIR, 1'b0);
    LBENn = 1'b1; RnW = 1'b1;
    #1; chk("cpu_buf_b", BUFENn, 1'b0); chk("cpu_dir_b", BUFDIR, 1'b1);

    // Random traffic against the model
    repeat (3000) begin
      drive_random();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
